// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - register-file write/read-1 arbiter: post-reset scrub, core passthrough, debug access insertion
module regfile_sequencer #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_we,
    input  logic [AW-1:0] core_rd,
    input  logic [DW-1:0] core_wdata,
    input  logic [AW-1:0] core_rs1,
    output logic          core_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          scrub_done
);

    typedef enum logic [1:0] {SCRUB, RUN, DBG, ACK} state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] scnt;
    logic          we_nxt;
    logic [AW-1:0] waddr_nxt;
    logic [DW-1:0] wdata_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SCRUB;
            scnt       <= AW'(1);
            scrub_done <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (state == SCRUB) begin
                scnt <= scnt + AW'(1);
                if (scnt == LAST_REG)
                    scrub_done <= 1'b1;
            end
            // x0 always reads back as zero, for both read and write accesses
            if (state == DBG)
                dbg_rdata <= (dbg_addr == '0) ? '0 : (dbg_we ? dbg_wdata : rf_rdata);
        end
    end

    always_comb begin
        state_nxt  = state;
        we_nxt     = 1'b0;
        waddr_nxt  = '0;
        wdata_nxt  = '0;
        rf_raddr   = core_rs1;
        core_stall = 1'b0;
        dbg_ack    = 1'b0;
        case (state)
            SCRUB: begin
                we_nxt     = 1'b1;
                waddr_nxt  = scnt;
                core_stall = 1'b1;
                if (scnt == LAST_REG)
                    state_nxt = RUN;
            end
            RUN: begin
                we_nxt    = core_we && (core_rd != '0);
                waddr_nxt = core_rd;
                wdata_nxt = core_wdata;
                if (dbg_req)
                    state_nxt = DBG;
            end
            DBG: begin
                core_stall = 1'b1;
                rf_raddr   = dbg_addr;
                we_nxt     = dbg_we && (dbg_addr != '0);
                waddr_nxt  = dbg_addr;
                wdata_nxt  = dbg_wdata;
                state_nxt  = ACK;
            end
            ACK: begin
                dbg_ack   = 1'b1;
                we_nxt    = core_we && (core_rd != '0);
                waddr_nxt = core_rd;
                wdata_nxt = core_wdata;
                if (!dbg_req)
                    state_nxt = RUN;
            end
            default: state_nxt = SCRUB;
        endcase
    end

    // The write port must be quiet while reset is held, independent of state
    assign rf_we    = rst & we_nxt;
    assign rf_waddr = rst ? waddr_nxt : '0;
    assign rf_wdata = rst ? wdata_nxt : '0;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer with a behavioural register file
module tb_regfile_sequencer;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_we;
    logic [AW-1:0] core_rd;
    logic [DW-1:0] core_wdata;
    logic [AW-1:0] core_rs1;
    logic          core_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          scrub_done;

    always #5 clk = ~clk;

    regfile_sequencer #(.NREGS(32), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata), .core_rs1(core_rs1),
        .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .scrub_done(scrub_done)
    );

    // Behavioural 32x32 register file, x0 hardwired zero
    logic [DW-1:0] regs [32];
    logic          preload;
    assign rf_rdata = (rf_raddr == '0) ? '0 : regs[rf_raddr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'hDEADBEEF;
        end else if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr [$];
    logic [DW-1:0] exp_ack [$];
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write and every rising dbg_ack is matched against the queues
    wr_t           mw;
    logic [DW-1:0] ma;
    logic          prev_ack = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rf_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
                end else begin
                    mw = exp_wr.pop_front();
                    check("wr_addr", 32'(rf_waddr), 32'(mw.a));
                    check("wr_data", rf_wdata, mw.d);
                end
            end
            if (dbg_ack && !prev_ack) begin
                if (exp_ack.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: rdata=%h, required no ack", dbg_rdata);
                end else begin
                    ma = exp_ack.pop_front();
                    check("ack_rdata", dbg_rdata, ma);
                end
            end
        end
        prev_ack <= dbg_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_stall", 32'(core_stall), 1);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_waddr", 32'(rf_waddr), 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_ack", 32'(dbg_ack), 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_scrub_done", 32'(scrub_done), 0);
    endtask

    // Entered at posedge+1 with rst low; releases reset and follows the 31-cycle scrub
    task automatic scrub_and_check();
        for (int i = 1; i < 32; i++) exp_wr.push_back('{AW'(i), 32'h0});
        tick();
        rst = 1'b1;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            check("scrub_stall", 32'(core_stall), 1);
            @(posedge clk);
        end
        #1;
        check("scrub_done", 32'(scrub_done), 1);
        check("run_stall", 32'(core_stall), 0);
    endtask

    task automatic dbg_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        int n;
        int stalls;
        exp_ack.push_back(exp_rd);
        if (we && a != '0) exp_wr.push_back('{a, wd});
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = wd;
        dbg_req   = 1'b1;
        n      = 0;
        stalls = 0;
        @(negedge clk);
        while (!dbg_ack && n < 20) begin
            if (core_stall) stalls++;
            n++;
            @(negedge clk);
        end
        check("ack_seen", 32'(dbg_ack), 1);
        check("ack_latency", 32'(n), 2);
        check("stall_cycles", 32'(stalls), 1);
        @(negedge clk);
        check("ack_hold", 32'(dbg_ack), 1);
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        check("ack_until_edge", 32'(dbg_ack), 1);
        tick();
        check("ack_drop", 32'(dbg_ack), 0);
        check("ack_drop_stall", 32'(core_stall), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; preload = 1'b1;
        core_we = 1'b0; core_rd = '0; core_wdata = '0; core_rs1 = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick();
        preload = 1'b0;
        check_reset_values();

        // Reset scrub over a DEADBEEF-filled file
        scrub_and_check();
        dbg_access(1'b0, 5'd31, 32'h0, 32'h0);

        // Passthrough
        core_rs1 = 5'd9;
        core_we = 1'b1; core_rd = 5'd5; core_wdata = 32'h12345678;
        exp_wr.push_back('{5'd5, 32'h12345678});
        @(negedge clk);
        check("pt_we", 32'(rf_we), 1);
        check("pt_raddr", 32'(rf_raddr), 9);
        check("pt_stall", 32'(core_stall), 0);
        tick();
        core_rd = 5'd0; core_wdata = 32'h99999999;
        @(negedge clk);
        check("pt_x0_we", 32'(rf_we), 0);
        tick();
        core_rd = 5'd7; core_wdata = 32'hA5A5A5A5;
        exp_wr.push_back('{5'd7, 32'hA5A5A5A5});
        tick();
        core_we = 1'b0;

        // Debug reads
        dbg_access(1'b0, 5'd7, 32'h0, 32'hA5A5A5A5);
        dbg_access(1'b0, 5'd5, 32'h0, 32'h12345678);

        // Debug write colliding with a core write presented in the DBG cycle
        exp_ack.push_back(32'hCAFEF00D);
        exp_wr.push_back('{5'd3, 32'hCAFEF00D});
        exp_wr.push_back('{5'd4, 32'h11112222});
        dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'hCAFEF00D; dbg_req = 1'b1;
        tick();
        check("col_dbg_stall", 32'(core_stall), 1);
        core_we = 1'b1; core_rd = 5'd4; core_wdata = 32'h11112222;
        tick();
        check("col_ack", 32'(dbg_ack), 1);
        check("col_ack_stall", 32'(core_stall), 0);
        tick();
        core_we = 1'b0; dbg_req = 1'b0;
        tick();
        check("col_ack_drop", 32'(dbg_ack), 0);
        dbg_access(1'b0, 5'd4, 32'h0, 32'h11112222);
        dbg_access(1'b0, 5'd3, 32'h0, 32'hCAFEF00D);

        // Debug write to x0 is acknowledged with zero data and no write
        dbg_access(1'b1, 5'd0, 32'h55555555, 32'h0);
        dbg_access(1'b0, 5'd0, 32'h0, 32'h0);

        // Request raised during reset/scrub is serviced right after scrub_done
        rst = 1'b0;
        #1;
        check_reset_values();
        exp_ack.push_back(32'h0);
        dbg_we = 1'b0; dbg_addr = 5'd3; dbg_req = 1'b1;
        scrub_and_check();
        @(negedge clk);
        check("pend_run_stall", 32'(core_stall), 0);
        check("pend_run_ack", 32'(dbg_ack), 0);
        tick();
        check("pend_dbg_stall", 32'(core_stall), 1);
        tick();
        check("pend_ack", 32'(dbg_ack), 1);
        dbg_req = 1'b0;
        tick();
        check("pend_ack_drop", 32'(dbg_ack), 0);

        // Reset while the DBG write is in flight aborts it
        dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'h77777777; dbg_req = 1'b1;
        tick();
        check("abort_dbg_stall", 32'(core_stall), 1);
        rst = 1'b0;
        #1;
        dbg_req = 1'b0;
        check_reset_values();
        scrub_and_check();
        dbg_access(1'b0, 5'd5, 32'h0, 32'h0);
        dbg_access(1'b0, 5'd1, 32'h0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        check("exp_wr_empty", 32'(exp_wr.size()), 0);
        check("exp_ack_empty", 32'(exp_ack.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
